// File: rtl/twos_complement_out_if.sv
// Handshake/bus bundle for the signed-result output stage: sign FIFO side,
// magnitude input side and the valid/ready result side.
interface twos_complement_out_if #(
  parameter int MAG_W      = 24,
  parameter int OUT_W      = 24,
  parameter int SIGN_DEPTH = 4
);
  localparam int CW = $clog2(SIGN_DEPTH) + 1;

  logic             sign_push;
  logic             sign_a;
  logic             sign_b;
  logic             sign_full;
  logic [CW-1:0]    sign_count;
  logic [MAG_W-1:0] mag_in;
  logic             mag_valid;
  logic             mag_ready;
  logic [OUT_W-1:0] y_out;
  logic             sat_out;
  logic             out_valid;
  logic             out_ready;
  logic             err_underflow;
  logic             err_overflow;

  modport slave (
    input  sign_push, sign_a, sign_b, mag_in, mag_valid, out_ready,
    output sign_full, sign_count, mag_ready, y_out, sat_out, out_valid,
           err_underflow, err_overflow
  );

  modport master (
    output sign_push, sign_a, sign_b, mag_in, mag_valid, out_ready,
    input  sign_full, sign_count, mag_ready, y_out, sat_out, out_valid,
           err_underflow, err_overflow
  );
endinterface

// File: rtl/twos_complement_out.sv
// Re-applies queued operand signs to unsigned product magnitudes, saturating
// into a signed OUT_W result held in a valid/ready output register.
module twos_complement_out #(
  parameter int MAG_W      = 24,
  parameter int OUT_W      = 24,
  parameter int SIGN_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  twos_complement_out_if.slave   bus
);
  localparam int PW = $clog2(SIGN_DEPTH);
  localparam int W  = ((MAG_W > OUT_W) ? MAG_W : OUT_W) + 1;
  localparam logic [W-1:0]     HALF    = W'(1) << (OUT_W - 1);
  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [SIGN_DEPTH-1:0] fifo_q;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic [OUT_W-1:0]      y_q;
  logic                  sat_q, vld_q, eu_q, eo_q;

  logic                  accept, empty, full, push_ok, pop, sign;
  logic [W-1:0]          mag_w, neg_w;
  logic [OUT_W-1:0]      res_y;
  logic                  res_sat;

  assign bus.mag_ready = !vld_q | bus.out_ready;
  assign accept  = bus.mag_valid & bus.mag_ready;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(SIGN_DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign push_ok = bus.sign_push & (!full | accept);
  assign pop     = accept & !empty;
  assign sign    = empty ? 1'b0 : fifo_q[rd_ptr];

  assign mag_w = W'(bus.mag_in);
  assign neg_w = (~mag_w) + W'(1);

  always_comb begin
    res_y   = '0;
    res_sat = 1'b0;
    if (!sign) begin
      if (mag_w > HALF - W'(1)) begin
        res_y   = POS_MAX;
        res_sat = 1'b1;
      end else begin
        res_y = mag_w[OUT_W-1:0];
      end
    end else if (mag_w >= HALF) begin
      // Exactly -2^(OUT_W-1) is representable, so only larger magnitudes clamp.
      res_y   = NEG_MIN;
      res_sat = (mag_w != HALF);
    end else begin
      res_y = neg_w[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      y_q    <= '0;
      sat_q  <= 1'b0;
      vld_q  <= 1'b0;
      eu_q   <= 1'b0;
      eo_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr] <= bus.sign_a ^ bus.sign_b;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (bus.sign_push & full & !accept) eo_q <= 1'b1;
      if (accept & empty)                 eu_q <= 1'b1;
      if (accept) begin
        y_q   <= res_y;
        sat_q <= res_sat;
        vld_q <= 1'b1;
      end else if (vld_q & bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.sign_full     = full;
  assign bus.sign_count    = count;
  assign bus.y_out         = y_q;
  assign bus.sat_out       = sat_q;
  assign bus.out_valid     = vld_q;
  assign bus.err_underflow = eu_q;
  assign bus.err_overflow  = eo_q;
endmodule

// File: tb/tb_twos_complement_out.sv
// Bench: two DUTs (OUT_W=24 and OUT_W=16) share one stimulus stream and are
// checked every cycle against a queue/arithmetic reference model.
module tb_twos_complement_out;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic push, sa, sb, mv, ordy;
  logic [23:0] mag;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  twos_complement_out_if #(.MAG_W(24), .OUT_W(24), .SIGN_DEPTH(DEPTH)) ifa ();
  twos_complement_out_if #(.MAG_W(24), .OUT_W(16), .SIGN_DEPTH(DEPTH)) ifb ();

  assign ifa.sign_push = push;  assign ifb.sign_push = push;
  assign ifa.sign_a    = sa;    assign ifb.sign_a    = sa;
  assign ifa.sign_b    = sb;    assign ifb.sign_b    = sb;
  assign ifa.mag_in    = mag;   assign ifb.mag_in    = mag;
  assign ifa.mag_valid = mv;    assign ifb.mag_valid = mv;
  assign ifa.out_ready = ordy;  assign ifb.out_ready = ordy;

  twos_complement_out #(.MAG_W(24), .OUT_W(24), .SIGN_DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa));
  twos_complement_out #(.MAG_W(24), .OUT_W(16), .SIGN_DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed value of the result, clamped to ow bits, returned as its ow-bit pattern.
  function automatic longint clamp(input int ow, input bit s, input longint m, output bit sat);
    longint v, hi, lo;
    v  = s ? -m : m;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -(longint'(1) << (ow - 1));
    sat = 0;
    if (v > hi) begin v = hi; sat = 1; end
    else if (v < lo) begin v = lo; sat = 1; end
    return v & ((longint'(1) << ow) - 1);
  endfunction

  // Reference model
  bit     q[$];
  bit     m_ov, m_sa, m_sb, m_eu, m_eo;
  longint m_ya, m_yb;

  always @(posedge clk) begin
    bit acc, s, pok, fl;
    if (rst) begin
      q.delete();
      m_ov = 0; m_ya = 0; m_yb = 0; m_sa = 0; m_sb = 0; m_eu = 0; m_eo = 0;
    end else begin
      acc = mv && (!m_ov || ordy);
      fl  = (q.size() == DEPTH);
      pok = push && (!fl || acc);
      if (push && fl && !acc) m_eo = 1;
      s = 0;
      if (acc) begin
        if (q.size() == 0) m_eu = 1;
        else s = q.pop_front();
      end
      if (pok) q.push_back(sa ^ sb);
      if (acc) begin
        m_ov = 1;
        m_ya = clamp(24, s, longint'(mag), m_sa);
        m_yb = clamp(16, s, longint'(mag), m_sb);
      end else if (m_ov && ordy) begin
        m_ov = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("a_y",     longint'(ifa.y_out), m_ya);
      chk("b_y",     longint'(ifb.y_out), m_yb);
      chk("a_sat",   longint'(ifa.sat_out), longint'(m_sa));
      chk("b_sat",   longint'(ifb.sat_out), longint'(m_sb));
      chk("a_valid", longint'(ifa.out_valid), longint'(m_ov));
      chk("b_valid", longint'(ifb.out_valid), longint'(m_ov));
      chk("a_ready", longint'(ifa.mag_ready), longint'(!m_ov || ordy));
      chk("a_count", longint'(ifa.sign_count), longint'(q.size()));
      chk("b_count", longint'(ifb.sign_count), longint'(q.size()));
      chk("a_full",  longint'(ifa.sign_full), longint'(q.size() == DEPTH));
      chk("a_eu",    longint'(ifa.err_underflow), longint'(m_eu));
      chk("a_eo",    longint'(ifa.err_overflow), longint'(m_eo));
      chk("b_eu",    longint'(ifb.err_underflow), longint'(m_eu));
      chk("b_eo",    longint'(ifb.err_overflow), longint'(m_eo));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Push one sign, then present one magnitude the following cycle.
  task automatic xact(input bit a, input bit b, input logic [23:0] m);
    push = 1; sa = a; sb = b; cyc();
    push = 0; mag = m; mv = 1; cyc();
    mv = 0;
  endtask

  initial begin
    logic [23:0] seq [4];
    push = 0; sa = 0; sb = 0; mag = '0; mv = 0; ordy = 1; rst = 1;
    cyc(); cyc();
    chk_en = 1;
    chk("rst_y", longint'(ifa.y_out), 0);
    chk("rst_valid", longint'(ifa.out_valid), 0);
    chk("rst_count", longint'(ifa.sign_count), 0);
    rst = 0;

    xact(1, 0, 24'd15);
    chk("t1_y", longint'(ifa.y_out), 64'hFFFFF1);
    chk("t1_sat", longint'(ifa.sat_out), 0);
    chk("t1_valid", longint'(ifa.out_valid), 1);
    chk("t1_count", longint'(ifa.sign_count), 0);

    xact(1, 1, 24'h400000);
    chk("t2_ya", longint'(ifa.y_out), 64'h400000);
    chk("t2_yb", longint'(ifb.y_out), 64'h7FFF);
    chk("t2_satb", longint'(ifb.sat_out), 1);
    xact(1, 0, 24'h0);
    chk("t3_y", longint'(ifa.y_out), 0);

    xact(1, 0, 24'h8000);
    chk("w16_negmin_y", longint'(ifb.y_out), 64'h8000);
    chk("w16_negmin_sat", longint'(ifb.sat_out), 0);
    chk("w24_neg8000", longint'(ifa.y_out), 64'hFF8000);
    xact(0, 0, 24'h8000);
    chk("w16_pos_y", longint'(ifb.y_out), 64'h7FFF);
    chk("w16_pos_sat", longint'(ifb.sat_out), 1);
    xact(0, 1, 24'h12345);
    chk("w16_neg_y", longint'(ifb.y_out), 64'h8000);
    chk("w16_neg_sat", longint'(ifb.sat_out), 1);

    // Fill, overflow, then push+pop while full
    for (int i = 0; i < 4; i++) begin
      push = 1; sa = (i % 2 == 0); sb = 0; cyc();
    end
    chk("fill_full", longint'(ifa.sign_full), 1);
    chk("fill_count", longint'(ifa.sign_count), 4);
    sa = 0; cyc();
    chk("ovf_flag", longint'(ifa.err_overflow), 1);
    chk("ovf_count", longint'(ifa.sign_count), 4);
    sa = 1; sb = 1; mv = 1; mag = 24'd1; cyc();
    push = 0;
    chk("pp_count", longint'(ifa.sign_count), 4);
    chk("pp_y", longint'(ifa.y_out), 64'hFFFFFF);
    seq[0] = 24'h1; seq[1] = 24'hFFFFFF; seq[2] = 24'h1; seq[3] = 24'h1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("drain_y%0d", i), longint'(ifa.y_out), longint'(seq[i]));
    end
    mv = 0;
    chk("drain_count", longint'(ifa.sign_count), 0);

    // Backpressure
    push = 1; sa = 0; sb = 0; cyc(); cyc();
    push = 0; ordy = 0; mv = 1; mag = 24'd5; cyc();
    chk("bp_y0", longint'(ifa.y_out), 5);
    mag = 24'd7;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_ready", longint'(ifa.mag_ready), 0);
      chk("bp_hold_y", longint'(ifa.y_out), 5);
    end
    ordy = 1; cyc();
    chk("bp_next_y", longint'(ifa.y_out), 7);
    chk("bp_valid", longint'(ifa.out_valid), 1);
    mv = 0; cyc();
    chk("bp_drop_valid", longint'(ifa.out_valid), 0);

    // Underflow then mid-stream reset
    mv = 1; mag = 24'd9; cyc();
    mv = 0;
    chk("uf_flag", longint'(ifa.err_underflow), 1);
    chk("uf_y", longint'(ifa.y_out), 9);
    push = 1; sa = 1; sb = 0; cyc(); cyc(); cyc();
    push = 0;
    chk("pre_rst_count", longint'(ifa.sign_count), 3);
    rst = 1; cyc();
    rst = 0;
    chk("mrst_y", longint'(ifa.y_out), 0);
    chk("mrst_count", longint'(ifa.sign_count), 0);
    chk("mrst_eu", longint'(ifa.err_underflow), 0);
    chk("mrst_eo", longint'(ifa.err_overflow), 0);
    chk("mrst_valid", longint'(ifa.out_valid), 0);

    // Randomized traffic; the compare process does the checking
    for (int i = 0; i < 3000; i++) begin
      push = ($urandom % 3) != 0;
      sa   = $urandom % 2;
      sb   = $urandom % 2;
      mv   = ($urandom % 5) < 2;
      ordy = ($urandom % 4) != 0;
      rst  = ($urandom % 400) == 0;
      case ($urandom % 10)
        0: mag = 24'h0;
        1: mag = 24'h1;
        2: mag = 24'h7FFF;
        3: mag = 24'h8000;
        4: mag = 24'h8001;
        5: mag = 24'h7FFFFF;
        6: mag = 24'h800000;
        7: mag = 24'hFFFFFF;
        default: mag = 24'($urandom);
      endcase
      cyc();
    end
    push = 0; mv = 0; rst = 0; cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
